// File: rtl/sfilt_mc.sv
// Multi-channel command-driven filter MAC: a pipelined signed multiplier feeds NCH accumulators,
// and output opcodes push {ch, word, ovf} into a credit-guarded first-word-fall-through FIFO.
module sfilt_mc #(
  parameter int DW          = 32,
  parameter int ACCW        = 64,
  parameter int NCH         = 4,
  parameter int MUL_STAGES  = 3,
  parameter int OFIFO_DEPTH = 4,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pushin,
  output logic                   stopout,
  input  logic [2:0]             cmd,
  input  logic [CHW-1:0]         ch,
  input  logic signed [DW-1:0]   q,
  input  logic signed [DW-1:0]   h,
  output logic                   pushout,
  input  logic                   stopin,
  output logic [CHW-1:0]         chout,
  output logic signed [DW-1:0]   z,
  output logic                   ovf
);

  localparam int PW   = $clog2(OFIFO_DEPTH);
  localparam int CW   = $clog2(OFIFO_DEPTH + MUL_STAGES + 1);
  localparam int LAST = MUL_STAGES - 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(OFIFO_DEPTH);
  localparam logic [DW-1:0] ZMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] ZMIN = {1'b1, {(DW-1){1'b0}}};

  logic                   v_p    [MUL_STAGES];
  logic [2:0]             cmd_p  [MUL_STAGES];
  logic [CHW-1:0]         ch_p   [MUL_STAGES];
  logic [6:0]             sh_p   [MUL_STAGES];
  logic signed [2*DW-1:0] prod_p [MUL_STAGES];

  logic signed [ACCW-1:0] acc [NCH];

  logic [DW-1:0]  mem_z   [OFIFO_DEPTH];
  logic [CHW-1:0] mem_ch  [OFIFO_DEPTH];
  logic           mem_ovf [OFIFO_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count, inflight;
  logic signed [DW-1:0] hold_z;
  logic [CHW-1:0]       hold_ch;
  logic                 hold_ovf;

  logic                   accept, push, pop;
  logic                   e_v, in_range;
  logic [2:0]             e_cmd;
  logic [CHW-1:0]         e_ch;
  logic [6:0]             e_sh;
  logic signed [ACCW-1:0] e_prod, cur, rnd;
  logic signed [ACCW:0]   shx;
  logic [DW-1:0]          sat;

  assign accept = pushin && !stopout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < MUL_STAGES; i++) begin
        v_p[i]    <= 1'b0;
        cmd_p[i]  <= '0;
        ch_p[i]   <= '0;
        sh_p[i]   <= '0;
        prod_p[i] <= '0;
      end
    end else begin
      v_p[0]    <= accept;
      cmd_p[0]  <= cmd;
      ch_p[0]   <= ch;
      sh_p[0]   <= h[6:0];
      prod_p[0] <= q * h;
      for (int unsigned i = 1; i < MUL_STAGES; i++) begin
        v_p[i]    <= v_p[i-1];
        cmd_p[i]  <= cmd_p[i-1];
        ch_p[i]   <= ch_p[i-1];
        sh_p[i]   <= sh_p[i-1];
        prod_p[i] <= prod_p[i-1];
      end
    end
  end

  assign e_v    = v_p[LAST];
  assign e_cmd  = cmd_p[LAST];
  assign e_ch   = ch_p[LAST];
  assign e_sh   = sh_p[LAST];
  assign e_prod = ACCW'(prod_p[LAST]);
  assign cur    = acc[e_ch];

  // The extra LSB catches the last bit shifted out; adding it back rounds halves toward +inf.
  always_comb begin
    shx = $signed({cur, 1'b0}) >>> e_sh;
    if (32'(e_sh) >= ACCW) rnd = '0;
    else                   rnd = shx[ACCW:1] + ACCW'(shx[0]);
  end

  assign in_range = (&cur[ACCW-1:DW-1]) | ~(|cur[ACCW-1:DW-1]);
  assign sat      = in_range ? cur[DW-1:0] : (cur[ACCW-1] ? ZMIN : ZMAX);
  assign push     = e_v && (e_cmd[2:1] == 2'b10);
  assign pop      = pushout && !stopin;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NCH; i++) acc[i] <= '0;
    end else if (e_v) begin
      case (e_cmd)
        3'd0:                 acc[e_ch] <= e_prod;
        3'd1:                 acc[e_ch] <= cur + e_prod;
        3'd2:                 acc[e_ch] <= cur - e_prod;
        3'd3:                 acc[e_ch] <= rnd;
        3'd4, 3'd5, 3'd6:     acc[e_ch] <= '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_z[wr_ptr]   <= e_cmd[0] ? sat : cur[DW-1:0];
      mem_ch[wr_ptr]  <= e_ch;
      mem_ovf[wr_ptr] <= !in_range;
    end
  end

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(OFIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      hold_z   <= '0;
      hold_ch  <= '0;
      hold_ovf <= 1'b0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop) begin
        rd_ptr   <= nxt(rd_ptr);
        hold_z   <= mem_z[rd_ptr];
        hold_ch  <= mem_ch[rd_ptr];
        hold_ovf <= mem_ovf[rd_ptr];
      end
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  // Output opcodes still in the multiplier pipeline hold a FIFO credit, so the FIFO cannot overflow.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < MUL_STAGES; i++)
      if (v_p[i] && cmd_p[i][2:1] == 2'b10) inflight = inflight + 1'b1;
  end

  assign stopout = (count + inflight) >= DEPTH_C;
  assign pushout = (count != '0);
  assign z       = pushout ? $signed(mem_z[rd_ptr]) : hold_z;
  assign chout   = pushout ? mem_ch[rd_ptr] : hold_ch;
  assign ovf     = pushout ? mem_ovf[rd_ptr] : hold_ovf;

endmodule

// File: tb/tb_sfilt_mc.sv
// Directed bench for sfilt_mc: an in-order command model predicts outputs and credit stall,
// checked every cycle, plus literal expectations for each directed scenario.
module tb_sfilt_mc;
  logic clk = 1'b0;
  logic rst, pushin, stopin, stopout, pushout, ovf;
  logic [2:0] cmd;
  logic [1:0] ch, chout;
  logic signed [31:0] q, h, z;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  sfilt_mc #(.DW(32), .ACCW(64), .NCH(4), .MUL_STAGES(3), .OFIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .pushin(pushin), .stopout(stopout), .cmd(cmd), .ch(ch),
    .q(q), .h(h), .pushout(pushout), .stopin(stopin), .chout(chout), .z(z), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct packed {
    logic [1:0]  c;
    logic [31:0] z;
    logic        o;
  } ent_t;

  longint macc [4];
  ent_t   mq [$];
  int     got_z [$];
  int     got_c [$];
  bit     got_o [$];
  int     rd_idx = 0;

  // Commands take effect in acceptance order; mq holds every accepted output not yet popped.
  task automatic mexec(input int c, input int op, input int qq, input int hh);
    longint prod, a, t, r;
    int s;
    bit o;
    ent_t e;
    prod = longint'(qq) * longint'(hh);
    a = macc[c];
    o = (a > 64'sd2147483647) || (a < -64'sd2147483648);
    case (op)
      0: macc[c] = prod;
      1: macc[c] = a + prod;
      2: macc[c] = a - prod;
      3: begin
        s = hh & 127;
        if (s >= 64) macc[c] = 0;
        else if (s != 0) begin
          t = a >>> s;
          r = (a >>> (s - 1)) & 64'sd1;
          macc[c] = t + r;
        end
      end
      4, 5: begin
        e.c = 2'(c);
        e.o = o;
        if (op == 5 && o) e.z = (a > 0) ? 32'h7FFFFFFF : 32'h80000000;
        else              e.z = a[31:0];
        mq.push_back(e);
        macc[c] = 0;
      end
      6: macc[c] = 0;
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mq.delete();
      for (int i = 0; i < 4; i++) macc[i] = 0;
    end else begin
      checks++;
      if (stopout !== (mq.size() >= 4)) begin
        errors++;
        $display("FAIL stopout: got %0b, required %0b (pending %0d)", stopout, (mq.size() >= 4), mq.size());
      end
      if (pushout === 1'b1) begin
        checks++;
        if (mq.size() == 0) begin
          errors++;
          $display("FAIL spurious_out: got ch=%0d z=%0d, required no output", chout, z);
        end else if (chout !== mq[0].c || z !== $signed(mq[0].z) || ovf !== mq[0].o) begin
          errors++;
          $display("FAIL out_word: got ch=%0d z=%0d ovf=%0b, required ch=%0d z=%0d ovf=%0b",
                   chout, z, ovf, mq[0].c, $signed(mq[0].z), mq[0].o);
        end
      end
      if (pushout === 1'b1 && stopin === 1'b0) begin
        got_z.push_back(int'(z));
        got_c.push_back(int'(chout));
        got_o.push_back(ovf);
        if (mq.size() > 0) void'(mq.pop_front());
      end
      if (pushin && !stopout) mexec(int'(ch), int'(cmd), int'(q), int'(h));
    end
  end

  task automatic send(input int c, input int op, input int qq, input int hh, output int ecyc);
    bit ok;
    ok = 1'b0;
    ecyc = -1;
    pushin = 1'b1;
    ch = 2'(c);
    cmd = 3'(op);
    q = qq;
    h = hh;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clk);
      ok = !stopout;
      @(posedge clk);
      #1;
    end
    pushin = 1'b0;
    if (ok) ecyc = cyc;
    else begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept for ch=%0d cmd=%0d, required accept within 60 cycles", c, op);
    end
  endtask

  task automatic s(input int c, input int op, input int qq, input int hh);
    int e;
    send(c, op, qq, hh, e);
  endtask

  task automatic expect_out(input int ec, input int ez, input bit eo, input string nm);
    int n;
    n = 0;
    while (got_z.size() <= rd_idx && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (got_z.size() <= rd_idx) begin
      errors++;
      $display("FAIL %s: got no output, required ch=%0d z=%0d ovf=%0b", nm, ec, ez, eo);
    end else begin
      if (got_c[rd_idx] != ec || got_z[rd_idx] != ez || got_o[rd_idx] != eo) begin
        errors++;
        $display("FAIL %s: got ch=%0d z=%0d ovf=%0b, required ch=%0d z=%0d ovf=%0b",
                 nm, got_c[rd_idx], got_z[rd_idx], got_o[rd_idx], ec, ez, eo);
      end
      rd_idx++;
    end
  endtask

  task automatic chk(input bit cond, input string nm, input int got, input int req);
    checks++;
    if (!cond) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, got, req);
    end
  endtask

  initial begin
    int e4, n, n0;
    rst = 1'b0; pushin = 1'b0; stopin = 1'b0; cmd = '0; ch = '0; q = '0; h = '0;
    repeat (3) @(posedge clk);
    #1;
    chk(pushout === 1'b0, "reset_pushout", int'(pushout), 0);
    chk(z === 32'sd0, "reset_z", int'(z), 0);
    chk(chout === 2'd0 && ovf === 1'b0, "reset_chout_ovf", int'({chout, ovf}), 0);
    chk(stopout === 1'b0, "reset_stopout", int'(stopout), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // basic MAC with accept-to-output latency
    s(0, 0, 3, 4); s(0, 1, -2, 5); send(0, 4, 0, 0, e4);
    n = 0;
    while (pushout !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    chk(cyc == e4 + 3, "mac_latency", cyc - e4, 3);
    expect_out(0, 2, 1'b0, "mac_basic");
    s(0, 4, 0, 0);
    expect_out(0, 0, 1'b0, "mac_cleared");

    // shift-round
    s(2, 0, 11, 1);  s(2, 3, 0, 2);   s(2, 4, 0, 0); expect_out(2, 3, 1'b0, "round_pos");
    s(2, 0, -11, 1); s(2, 3, 0, 2);   s(2, 4, 0, 0); expect_out(2, -3, 1'b0, "round_neg");
    s(2, 0, 6, 1);   s(2, 3, 0, 2);   s(2, 4, 0, 0); expect_out(2, 2, 1'b0, "round_tie_pos");
    s(2, 0, -6, 1);  s(2, 3, 0, 2);   s(2, 4, 0, 0); expect_out(2, -1, 1'b0, "round_tie_neg");
    s(2, 0, 11, 1);  s(2, 3, 0, 0);   s(2, 4, 0, 0); expect_out(2, 11, 1'b0, "round_s0");
    s(2, 0, -11, 1); s(2, 3, 0, 127); s(2, 4, 0, 0); expect_out(2, 0, 1'b0, "round_s127");

    // saturation and overflow boundaries
    s(3, 0, 65536, 65536);  s(3, 5, 0, 0); expect_out(3, 2147483647, 1'b1, "sat_pos");
    s(3, 0, 65536, 65536);  s(3, 4, 0, 0); expect_out(3, 0, 1'b1, "trunc_ovf");
    s(3, 0, -65536, 65536); s(3, 5, 0, 0); expect_out(3, int'(32'h80000000), 1'b1, "sat_neg");
    s(3, 0, 2147483647, 1); s(3, 5, 0, 0); expect_out(3, 2147483647, 1'b0, "sat_edge_max");
    s(3, 0, int'(32'h80000000), 1); s(3, 4, 0, 0); expect_out(3, int'(32'h80000000), 1'b0, "trunc_edge_min");
    s(3, 0, 65536, 32768);  s(3, 5, 0, 0); expect_out(3, 2147483647, 1'b1, "sat_just_over");

    // MSU, clear, no-op
    s(1, 0, 5, 1); s(1, 2, 3, 4);   s(1, 4, 0, 0); expect_out(1, -7, 1'b0, "msu");
    s(1, 0, 9, 9); s(1, 6, 0, 0);   s(1, 4, 0, 0); expect_out(1, 0, 1'b0, "clear");
    s(1, 0, 4, 4); s(1, 7, 99, 99); s(1, 4, 0, 0); expect_out(1, 16, 1'b0, "noop");

    // channel interleave
    for (int c = 0; c < 4; c++) s(c, 0, c + 1, 10);
    for (int c = 0; c < 4; c++) s(c, 1, 1, 1);
    for (int c = 0; c < 4; c++) s(c, 4, 0, 0);
    for (int c = 0; c < 4; c++) expect_out(c, (c + 1) * 10 + 1, 1'b0, "interleave");

    // backpressure
    for (int c = 0; c < 4; c++) s(c, 0, 100 + c, 1);
    stopin = 1'b1;
    n0 = got_z.size();
    fork
      begin
        for (int c = 0; c < 4; c++) s(c, 4, 0, 0);
        s(0, 0, 200, 1); s(0, 4, 0, 0);
        s(1, 0, 201, 1); s(1, 4, 0, 0);
      end
      begin
        repeat (12) @(posedge clk);
        #1;
        chk(stopout === 1'b1, "bp_stopout_high", int'(stopout), 1);
        chk(pushout === 1'b1 && z === 32'sd100, "bp_head_hold", int'(z), 100);
        chk(got_z.size() == n0, "bp_no_pop", got_z.size() - n0, 0);
        stopin = 1'b0;
      end
    join
    expect_out(0, 100, 1'b0, "bp_0");
    expect_out(1, 101, 1'b0, "bp_1");
    expect_out(2, 102, 1'b0, "bp_2");
    expect_out(3, 103, 1'b0, "bp_3");
    expect_out(0, 200, 1'b0, "bp_4");
    expect_out(1, 201, 1'b0, "bp_5");
    repeat (8) @(posedge clk);
    #1;
    chk(got_z.size() == rd_idx, "bp_no_dup", got_z.size(), rd_idx);

    // reset mid-operation
    stopin = 1'b1;
    s(0, 0, 7, 1); s(0, 4, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    s(1, 0, 5, 1); s(2, 0, 6, 1); s(1, 4, 0, 0); s(2, 4, 0, 0);
    rst = 1'b0;
    #1;
    chk(pushout === 1'b0, "rst_pushout", int'(pushout), 0);
    chk(z === 32'sd0 && chout === 2'd0 && ovf === 1'b0, "rst_outputs", int'(z), 0);
    chk(stopout === 1'b0, "rst_stopout", int'(stopout), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    stopin = 1'b0;
    n0 = got_z.size();
    repeat (10) @(posedge clk);
    #1;
    chk(got_z.size() == n0, "rst_discard", got_z.size() - n0, 0);
    s(1, 1, 3, 3); s(1, 4, 0, 0);
    expect_out(1, 9, 1'b0, "rst_fresh");

    repeat (10) @(posedge clk);
    #1;
    chk(mq.size() == 0, "model_drained", mq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, required finish before 200000");
    $fatal(1);
  end
endmodule

// File: doc/sfilt_mc.md
Name: sfilt_mc

Overview:
Multi-channel, parametrised successor to the single-accumulator command-driven filter MAC.
- Each accepted command carries a channel index, a sample q, a coefficient h and an opcode.
- Products from a pipelined signed multiplier are accumulated into one of NCH independent accumulators.
- Adds over the previous generation: multiply-subtract, saturating output, overflow flag, channel tag on output, output FIFO with backpressure.
- Sits between the sample/coefficient sequencer and the downstream result consumer in the filter datapath.

Parameters:
- DW, 32, signed width of q, h and z.
- ACCW, 64, signed accumulator width; must be ≥ 2*DW.
- NCH, 4, number of channels/accumulators; ≥ 1.
- MUL_STAGES, 3, multiplier pipeline depth. Defines the accept-to-accumulate latency.
- OFIFO_DEPTH, 4, output FIFO entries; ≥ 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- pushin  in  1  command valid.
- stopout  out  1  not ready. A command is accepted only on edges where pushin=1 and stopout=0.
- cmd  in  3  opcode (see Behaviour).
- ch  in  max(1,clog2(NCH))  target channel.
- q  in  DW  signed sample.
- h  in  DW  signed coefficient. For cmd 3, h[6:0] is the shift amount.
- pushout  out  1  output valid (FIFO not empty).
- stopin  in  1  downstream not ready. The FIFO head pops on an edge where pushout=1 and stopin=0.
- chout  out  max(1,clog2(NCH))  channel of the output word.
- z  out  DW  output word.
- ovf  out  1  the acc value behind z did not fit in signed DW.

Behaviour:
- Reset (rst=0, async): all accumulators 0, pipeline valids 0, FIFO empty.
  - Outputs: pushout=0, z=0, chout=0, ovf=0, stopout=0.
  - In-flight commands are discarded; nothing is emitted for them after reset releases.
- Pipeline:
  - The command accepted at edge E registers q/h/cmd/ch/valid.
  - The product q*h (full 2*DW, sign-extended to ACCW) and the aligned cmd/ch/h[6:0] are ready to act at edge E+MUL_STAGES.
  - The accumulator for ch updates at edge E+MUL_STAGES; output commands write the FIFO at that same edge.
  - Accepted commands never stall internally.
- Opcodes (apply to acc[ch] at the execute stage):
  - 0 load: acc = product.
  - 1 MAC: acc = acc + product (wraps at ACCW).
  - 2 MSU: acc = acc - product (wraps at ACCW).
  - 3 shift-round: s = h[6:0]; {t,r} = {acc,1'b0} >>> s; acc = t + r.
    - s=0 leaves acc unchanged; ties round toward +inf.
    - Any s ≥ ACCW yields 0.
  - 4 output-truncate: push {ch, acc[DW-1:0], ovf} to the FIFO, then acc = 0.
  - 5 output-saturate: push {ch, clamp(acc), ovf}, then acc = 0.
    - clamp gives 2^(DW-1)-1 or -2^(DW-1) when out of range.
  - 6 clear: acc = 0, no output.
  - 7 no-op.
  - For opcodes 4 and 5, ovf = 1 iff acc ∉ [-2^(DW-1), 2^(DW-1)-1].
- Channels are independent. Back-to-back commands to the same channel see the previous result; no bubbles are required.
- Output FIFO: first-word-fall-through.
  - A word written at edge X is visible at z/chout/ovf with pushout=1 immediately after X.
  - A simultaneous push and pop on a non-empty FIFO keeps occupancy unchanged.
  - On an empty FIFO with a push and no pop, pushout rises after that edge.
- Credit/backpressure:
  - stopout = 1 whenever (FIFO occupancy + output opcodes 4/5 in flight in the pipeline) ≥ OFIFO_DEPTH.
  - stopout is registered-free combinational from internal state only; it does not depend on pushin, cmd or stopin in the same cycle.
  - Non-accepted commands (pushin=1 while stopout=1) are ignored entirely; upstream must hold them.
  - The FIFO therefore never overflows. Popping an empty FIFO is impossible because pop requires pushout=1.
- z, chout and ovf hold the head entry while stopin=1. When empty they hold the last value (0 after reset).
- Arithmetic is signed two's complement throughout; the shift is arithmetic.

Test Plan:
- Basic MAC, ch0:
  - Stimulus: cmd0 q=3 h=4; cmd1 q=-2 h=5; cmd4, consecutive cycles, stopin=0.
  - Response: pushout=1 exactly MUL_STAGES edges after the cmd4 accept, z=2, chout=0, ovf=0; acc[0]=0 afterwards.
- Rounding:
  - Positive: load acc=11 (q=11 h=1), cmd3 h=2, cmd4 → z=3.
  - Negative: load acc=-11, cmd3 h=2, cmd4 → z=-3.
  - Limits: cmd3 h=0 leaves acc unchanged; h=127 gives 0.
- Saturation/ovf:
  - Load acc=2^32 (q=65536 h=65536), then cmd5 → z=0x7FFFFFFF, ovf=1.
  - Same load, then cmd4 → z=0, ovf=1.
  - q=-65536 h=65536, cmd5 → z=0x80000000, ovf=1.
- Channel interleave:
  - Alternate ch0/ch1/ch2/ch3 cmd0 (q=ch+1, h=10), cmd1 (q=1, h=1), cmd4 per channel, each back-to-back.
  - Response: outputs in command order, z=11,21,31,41 with matching chout.
- Backpressure:
  - Hold stopin=1 and issue 6 output commands back-to-back.
  - Response: stopout=1 once 4 outputs are accepted; later commands are not accepted while it is high.
  - Release stopin: all 4 pop in order, then the remaining 2 are accepted and emitted; no loss, no duplicates.
- Reset mid-operation:
  - Pull rst low with 2 output commands in flight and 1 FIFO entry.
  - Response: pushout=0 immediately; nothing emitted after release; a fresh cmd0/cmd4 works with acc starting from 0.
